fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode-stage control unit.
- Generates the PC and issues word requests to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers returned instructions and presents them in the IF/ID pipeline register, with opcode/funct3/funct7 slices for the control unit.
- Handles redirects from EX (jump/branch), decode stalls, and fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MAX_INFLIGHT, 2, max requests accepted by memory but not yet answered, plus buffered responses.
- NOP_INSTR, 32'h0000_0013, instruction presented on bubbles and faults (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address (= pc).
- imem_rsp_valid  in  1  response valid; always accepted, no backpressure.
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  access fault for this response.
- redirect_valid  in  1  EX jump/branch taken.
- redirect_pc  in  32  new fetch target.
- id_stall  in  1  decode cannot accept a new instruction this cycle.
- if_id_valid  out  1  IF/ID register holds a live instruction.
- if_id_instr  out  32  instruction.
- if_id_pc  out  32  address of if_id_instr.
- if_id_pc_plus4  out  32  if_id_pc + 4, for JAL/JALR writeback.
- if_id_opcode  out  7  if_id_instr[6:0].
- if_id_funct3  out  3  if_id_instr[14:12].
- if_id_funct7  out  7  if_id_instr[31:25].
- if_id_fault  out  1  entry is a fault marker, not a real instruction.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Deassertion is synchronised externally.
- Reset values:
  - pc = RESET_PC; state = FETCH; inflight = 0; kill = 0; FIFO empty.
  - if_id_valid = 0, if_id_instr = NOP_INSTR, if_id_pc = 0, if_id_pc_plus4 = 4, if_id_fault = 0.
  - imem_req_valid = 0 while rst_n = 0.
- Instruction memory resets on the same rst_n; no pre-reset response may arrive after reset.
- States:
  - FETCH: issuing.
  - HALTED: no requests; waits for redirect.
- Request channel:
  - imem_req_valid = (state == FETCH) && (inflight + fifo_count < MAX_INFLIGHT). It does not depend on imem_req_ready.
  - imem_req_addr = pc. Address is held while valid && !ready, except when redirect_valid changes pc.
  - Handshake (valid && ready): pc <= pc + 4 and inflight++, unless a redirect occurs the same cycle.
- Responses:
  - Return in request order. Each response decrements inflight.
  - If kill > 0, the response is dropped and kill decrements.
  - Otherwise the entry {data, pc_of_request, err} is captured.
  - The request PC for each in-flight slot is tracked in a small in-order tag queue.
- Capture path:
  - If the FIFO is empty and IF/ID is free (!if_id_valid || !id_stall), the response loads IF/ID directly. Latency: response edge N, so if_id_valid = 1 after edge N.
  - Otherwise the response enters the 2-entry FIFO.
  - The FIFO head loads IF/ID whenever IF/ID is free.
  - If IF/ID is freed with nothing available, if_id_valid <= 0.
- Stall: while id_stall = 1 and if_id_valid = 1, all IF/ID outputs hold. Credit accounting guarantees the FIFO never overflows.
- Redirect (highest priority):
  - pc <= redirect_pc; FIFO flushed; if_id_valid <= 0.
  - kill <= inflight after this cycle's events, including a request accepted and a response arriving this same cycle. Both are treated as stale.
  - state <= FETCH.
  - redirect overrides id_stall.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - No request is issued; state <= HALTED.
  - The next free IF/ID slot receives if_id_fault = 1, if_id_instr = NOP_INSTR, if_id_pc = redirect_pc.
- imem_rsp_err on a live response:
  - The entry is delivered with if_id_fault = 1 and instr = NOP_INSTR; state <= HALTED.
  - Kill is set for the remaining inflight.
- Wrap-around: pc + 4 wraps modulo 2^32 silently.

Decomposition:
- Shared package (inst_defs.sv):
  - NOP_INSTR.
  - OPCODE/FUNCT_3/FUNCT_7 bit-range macros.
  - fetch_state_t enum {FETCH, HALTED}.
  - fetch_entry_t struct {instr, pc, fault}.
- Sub-module fetch_rsp_fifo: 2-entry FIFO of fetch_entry_t with push, pop, flush, count and empty, async active-low reset.

Test Plan:
- Reset release, imem_req_ready = 1, one-cycle response latency returning 32'h00500093 → requests at 0x0, 0x4, 0x8. After the first response, if_id_valid = 1, if_id_instr = 32'h00500093, if_id_pc = 0, if_id_pc_plus4 = 4, if_id_opcode = 7'h13.
- id_stall held 3 cycles with responses flowing → IF/ID holds; FIFO fills to 2; imem_req_valid deasserts at inflight + fifo_count = 2. On release, instructions appear in order 0x4, 0x8 with none lost.
- redirect_valid with redirect_pc = 0x100, same cycle as a response and with one request inflight → both stale responses are dropped. Next if_id_pc = 0x100; if_id_valid = 0 the cycle after the redirect.
- redirect_pc = 0x102 → no request issued. Fault entry with if_id_fault = 1, if_id_pc = 0x102, instr = 0x00000013. State stays HALTED until redirect to 0x200 resumes fetch.
- imem_rsp_err = 1 on the response for 0x8 → fault entry at pc 0x8; fetch halts; a later response for 0xC is discarded.
- rst_n asserted mid-stream with FIFO holding 2 entries → all outputs return to reset values immediately; first request after release is to RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch states, the
// buffered fetch entry and the RV32 field positions used by decode.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OPCODE_HI = 6;
  localparam int OPCODE_LO = 0;
  localparam int FUNCT3_HI = 14;
  localparam int FUNCT3_LO = 12;
  localparam int FUNCT7_HI = 31;
  localparam int FUNCT7_LO = 25;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  // A faulting entry never carries the memory word, only the NOP filler.
  function automatic fetch_entry_t make_entry(input logic [31:0] data,
                                              input logic [31:0] pc,
                                              input logic        fault);
    fetch_entry_t e;
    e.instr = fault ? NOP_INSTR : data;
    e.pc    = pc;
    e.fault = fault;
    return e;
  endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// Two-entry in-order buffer for fetch responses that could not go straight
// into IF/ID. Flush with a simultaneous push leaves exactly the pushed entry.
module fetch_rsp_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o,
  output logic         empty_o
);

  fetch_entry_t mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_q <= 1'b0;
      if (push_i) begin
        mem_q[0] <= entry_i;
        wr_q     <= 1'b1;
        count_q  <= 2'd1;
      end else begin
        wr_q    <= 1'b0;
        count_q <= 2'd0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= entry_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, in-order request/response tracking,
// response buffering and the IF/ID register feeding the decode control unit.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MAX_INFLIGHT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         imem_rsp_err,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         id_stall,
  output logic         if_id_valid,
  output logic [31:0]  if_id_instr,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_pc_plus4,
  output logic [6:0]   if_id_opcode,
  output logic [2:0]   if_id_funct3,
  output logic [6:0]   if_id_funct7,
  output logic         if_id_fault,
  output fetch_state_t dbg_state_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   inflight_q, inflight_d;
  logic [1:0]   kill_q, kill_d;
  logic [31:0]  tag_q [2];
  logic [31:0]  tag_d [2];
  logic         ifv_q, ifv_d;
  fetch_entry_t ifid_q, ifid_d;

  logic         fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_in, fifo_head;

  logic         credit_ok, hs, misaligned, live_rsp, ifid_free, tag_wr_idx;
  fetch_entry_t rsp_entry;

  // Request channel: a transfer happens on any edge where valid && ready.
  // valid never looks at ready, and the address only moves on a transfer or
  // a redirect. Responses arrive in request order and are never back-pressured.
  assign credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_count}) < 3'(MAX_INFLIGHT);
  assign imem_req_valid = rst_n && (state_q == FETCH) && credit_ok;
  assign imem_req_addr  = pc_q;
  assign hs         = imem_req_valid && imem_req_ready;
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign live_rsp   = imem_rsp_valid && (kill_q == 2'd0) && !redirect_valid;
  assign rsp_entry  = make_entry(imem_rsp_data, tag_q[0], imem_rsp_err);
  assign ifid_free  = !ifv_q || !id_stall;
  // Credits keep inflight <= 1 whenever a request is accepted.
  assign tag_wr_idx = inflight_q[0] & ~imem_rsp_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q + {1'b0, hs} - {1'b0, imem_rsp_valid};
    kill_d     = kill_q;
    tag_d      = tag_q;
    ifv_d      = ifv_q;
    ifid_d     = ifid_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    fifo_in    = rsp_entry;

    if (imem_rsp_valid) begin
      tag_d[0] = tag_q[1];
      if (kill_q != 2'd0) begin
        kill_d = kill_q - 2'd1;
      end
    end
    if (hs) begin
      tag_d[tag_wr_idx] = pc_q;
      pc_d              = pc_q + 32'd4;
    end

    if (redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old path.
      pc_d         = redirect_pc;
      kill_d       = inflight_d;
      fifo_flush   = 1'b1;
      ifv_d        = 1'b0;
      ifid_d.instr = NOP_INSTR;
      ifid_d.fault = 1'b0;
      state_d      = misaligned ? HALTED : FETCH;
      if (misaligned) begin
        fifo_push = 1'b1;
        fifo_in   = make_entry('0, redirect_pc, 1'b1);
      end
    end else begin
      if (live_rsp && imem_rsp_err) begin
        state_d = HALTED;
        kill_d  = inflight_d;
      end
      if (ifid_free) begin
        if (!fifo_empty) begin
          ifv_d     = 1'b1;
          ifid_d    = fifo_head;
          fifo_pop  = 1'b1;
          fifo_push = live_rsp;
        end else if (live_rsp) begin
          ifv_d  = 1'b1;
          ifid_d = rsp_entry;
        end else begin
          ifv_d        = 1'b0;
          ifid_d.instr = NOP_INSTR;
          ifid_d.fault = 1'b0;
        end
      end else begin
        fifo_push = live_rsp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      inflight_q <= 2'd0;
      kill_q     <= 2'd0;
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
      ifv_q      <= 1'b0;
      ifid_q     <= '{instr: NOP_INSTR, pc: 32'd0, fault: 1'b0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      tag_q      <= tag_d;
      ifv_q      <= ifv_d;
      ifid_q     <= ifid_d;
    end
  end

  fetch_rsp_fifo u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .entry_i (fifo_in),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign if_id_valid    = ifv_q;
  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc       = ifid_q.pc;
  assign if_id_pc_plus4 = ifid_q.pc + 32'd4;
  assign if_id_opcode   = ifid_q.instr[OPCODE_HI:OPCODE_LO];
  assign if_id_funct3   = ifid_q.instr[FUNCT3_HI:FUNCT3_LO];
  assign if_id_funct7   = ifid_q.instr[FUNCT7_HI:FUNCT7_LO];
  assign if_id_fault    = ifid_q.fault;
  assign dbg_state_o    = state_q;

endmodule
